ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.

---
 rtl/ps2_host_tx_if.sv | 19 +
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a host controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start/8 data/odd parity/stop, device ACK check.
// Optional device-clock watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
//  state     | meaning
//  IDLE      | lines released, ready for a command byte
//  INHIBIT   | ps2 clock held low for request-to-send
//  START     | start bit on the wire, waiting for device fall #1
//  SHIFT     | driving D0..D7 on device falls #1..#8
//  PARITY    | parity on the wire, waiting for fall #10 to release data (stop)
//  ACK       | waiting for fall #11 to sample the device ACK
//  WAIT_IDLE | waiting for both lines high before reporting the result
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    ps2_host_tx_if.slave       bus,
    input  logic               ps2_clock_in,
    input  logic               ps2_data_in,
    output logic               ps2_clock_oe,
    output logic               ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, PARITY, ACK, WAIT_IDLE
    } state_t;

    state_t             state, state_next;
    logic               clk_s1, clk_s2, clk_prev;
    logic               data_s1, data_s2;
    logic               fall;
    logic               clock_oe_next, data_oe_next;
    logic [7:0]         shreg, shreg_next;
    logic               parity, parity_next;
    logic [3:0]         bit_idx, bit_idx_next;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_next;
    logic               nack, nack_next;
    logic               done_r, error_r, done_next, error_next;
    logic               timeout_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clock_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timed;

    assign timed       = (state != IDLE) && (state != INHIBIT);
    assign timeout_hit = timed && (to_cnt == TO_LAST);

    // Cleared on every device fall and on any state change, so it measures the gap between falls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!timed || fall || (state_next != state)) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            shreg        <= '0;
            parity       <= 1'b0;
            bit_idx      <= '0;
            inh_cnt      <= '0;
            nack         <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state        <= state_next;
            ps2_clock_oe <= clock_oe_next;
            ps2_data_oe  <= data_oe_next;
            shreg        <= shreg_next;
            parity       <= parity_next;
            bit_idx      <= bit_idx_next;
            inh_cnt      <= inh_cnt_next;
            nack         <= nack_next;
            done_r       <= done_next;
            error_r      <= error_next;
        end
    end

    always_comb begin
        state_next    = state;
        clock_oe_next = ps2_clock_oe;
        data_oe_next  = ps2_data_oe;
        shreg_next    = shreg;
        parity_next   = parity;
        bit_idx_next  = bit_idx;
        inh_cnt_next  = inh_cnt;
        nack_next     = nack;
        done_next     = 1'b0;
        error_next    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_next    = INHIBIT;
                    clock_oe_next = 1'b1;
                    data_oe_next  = 1'b0;
                    inh_cnt_next  = '0;
                    shreg_next    = bus.tx_data;
                    parity_next   = ~^bus.tx_data;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    state_next    = START;
                    clock_oe_next = 1'b0;
                    data_oe_next  = 1'b1;
                end else begin
                    inh_cnt_next = inh_cnt + 1'b1;
                end
            end
            START: begin
                if (fall) begin
                    data_oe_next = ~shreg[0];
                    shreg_next   = {1'b0, shreg[7:1]};
                    bit_idx_next = 4'd1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (bit_idx == 4'd8) begin
                        data_oe_next = ~parity;
                        state_next   = PARITY;
                    end else begin
                        data_oe_next = ~shreg[0];
                        shreg_next   = {1'b0, shreg[7:1]};
                        bit_idx_next = bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    data_oe_next = 1'b0;
                    state_next   = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    nack_next  = data_s2;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                    state_next = IDLE;
                    done_next  = ~nack;
                    error_next = nack;
                end
            end
            default: state_next = IDLE;
        endcase

        if (timeout_hit) begin
            state_next    = IDLE;
            clock_oe_next = 1'b0;
            data_oe_next  = 1'b0;
            done_next     = 1'b0;
            error_next    = 1'b1;
        end
    end

    assign bus.tx_ready = (state == IDLE);
    assign bus.tx_busy  = (state != IDLE);
    assign bus.tx_done  = done_r;
    assign bus.tx_error = error_r;

endmodule
